ledpanel_row_loader: RTL and testbench

LEDPANEL_ROW_LOADER -- requirements
Module: ledpanel_row_loader

---
 rtl/ledpanel_row_loader.sv | 87 ++++++++
 tb/tb_ledpanel_row_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ledpanel_row_loader.sv
// ledpanel_row_loader: parses 130-byte row packets (panel, row, 64 RGB565 pixels) into panel writes.
// Define LEDPANEL_LOADER_ERRCNT_EN to build the saturating malformed-packet counter on err_count.
module ledpanel_row_loader (
    input  logic        display_clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  ctrl_en,
    output logic [15:0] ctrl_addr,
    output logic [15:0] ctrl_wdat,
    output logic        row_done,
    output logic [15:0] err_count
);
    typedef enum logic [2:0] {S_PANEL, S_ROW, S_PIX_LO, S_PIX_HI, S_DROP} state_t;
    state_t state;
    logic [7:0] panel, lo;
    logic [4:0] row;
    logic [5:0] col;
    logic acc;
    assign acc = in_valid && in_ready;

    always_ff @(posedge display_clock) begin
        if (reset) begin
            state <= S_PANEL;
            col <= '0;
            in_ready <= 1'b0;
            ctrl_en <= 8'hFF;
            ctrl_addr <= '0;
            ctrl_wdat <= '0;
            row_done <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            ctrl_en <= 8'hFF;
            row_done <= 1'b0;
            if (acc) begin
                case (state)
                    S_PANEL: begin
                        panel <= in_data;
                        col <= '0;
                        state <= in_last ? S_PANEL : (in_data == 8'hFF ? S_DROP : S_ROW);
                    end
                    S_ROW: begin
                        row <= in_data[4:0];
                        state <= in_last ? S_PANEL : (in_data >= 8'd32 ? S_DROP : S_PIX_LO);
                    end
                    S_PIX_LO: begin
                        lo <= in_data;
                        state <= in_last ? S_PANEL : S_PIX_HI;
                    end
                    S_PIX_HI: begin
                        ctrl_en <= panel;
                        ctrl_addr <= {5'b0, row, col};
                        ctrl_wdat <= {in_data, lo};
                        col <= col + 6'd1;
                        row_done <= in_last && col == 6'd63;
                        // an overlong packet still gets its column-63 write, then drains in S_DROP
                        state <= in_last ? S_PANEL : (col == 6'd63 ? S_DROP : S_PIX_LO);
                    end
                    default: if (in_last) state <= S_PANEL;
                endcase
            end
        end
    end

`ifdef LEDPANEL_LOADER_ERRCNT_EN
    logic bad;
    always_comb begin
        bad = 1'b0;
        if (acc)
            case (state)
                S_PANEL:  bad = in_last || in_data == 8'hFF;
                S_ROW:    bad = in_last || in_data >= 8'd32;
                S_PIX_LO: bad = in_last;
                S_PIX_HI: bad = in_last != (col == 6'd63);
                default:  bad = 1'b0;
            endcase
    end

    always_ff @(posedge display_clock)
        if (reset) err_count <= '0;
        else if (bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`else
    assign err_count = 16'h0000;
`endif
endmodule

// File: tb/tb_ledpanel_row_loader.sv
// tb_ledpanel_row_loader: random packets with gaps checked against a packet-level reference model.
// Honours LEDPANEL_LOADER_ERRCNT_EN for the expected err_count.
module tb_ledpanel_row_loader;
    logic display_clock = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, row_done;
    logic [7:0] ctrl_en;
    logic [15:0] ctrl_addr, ctrl_wdat, err_count;

    ledpanel_row_loader dut (
        .display_clock(display_clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .ctrl_en(ctrl_en),
        .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat),
        .row_done(row_done),
        .err_count(err_count)
    );

    always #5 display_clock = ~display_clock;

    typedef struct packed {
        logic [7:0]  en;
        logic [15:0] addr;
        logic [15:0] dat;
        logic        rd;
    } wr_t;

    wr_t obs[$], exp_q[$];
    logic [7:0] pkt[$];
    int n_tests = 0, n_fail = 0, rd_seen = 0, exp_err = 0, exp_rd = 0;

    always @(negedge display_clock) begin
        if (ctrl_en != 8'hFF) obs.push_back({ctrl_en, ctrl_addr, ctrl_wdat, row_done});
        if (row_done) rd_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Whole-packet view: pixels fully received are written, capped at 64; only an exact
    // 130-byte packet with a real panel and row < 32 is well-formed.
    task automatic model_pkt(input bit count_err);
        int n = pkt.size();
        int npix;
        bit good = n == 130 && pkt[0] != 8'hFF && pkt[1] < 8'd32;
        exp_q.delete();
        exp_rd = good ? 1 : 0;
        if (n >= 2 && pkt[0] != 8'hFF && pkt[1] < 8'd32) begin
            npix = (n - 2) / 2;
            if (npix > 64) npix = 64;
            for (int k = 0; k < npix; k++)
                exp_q.push_back({pkt[0], 16'(pkt[1] * 64 + k), pkt[3 + 2 * k], pkt[2 + 2 * k], 1'(good && k == 63)});
        end
        if (count_err && !good && exp_err < 65535) exp_err++;
    endtask

    task automatic make_pkt(input logic [7:0] panel, input logic [7:0] row, input int n);
        pkt.delete();
        pkt.push_back(panel);
        if (n > 1) pkt.push_back(row);
        for (int i = 2; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic run_pkt(input int gap_pct, input int reset_at);
        int base = obs.size();
        int rd0 = rd_seen;
        int t = 0;
        int n = pkt.size();
        while (!in_ready && t < 20) begin
            @(posedge display_clock); #1;
            t++;
        end
        check("ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < n && i != reset_at; i++) begin
            repeat (($urandom_range(99) < gap_pct) ? $urandom_range(1, 4) : 0) begin
                in_valid = 1'b0;
                in_last = 1'($urandom);
                in_data = 8'($urandom);
                @(posedge display_clock); #1;
            end
            in_valid = 1'b1;
            in_data = pkt[i];
            in_last = (i == n - 1);
            @(posedge display_clock); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (3) @(posedge display_clock);
        #1;
        if (reset_at >= 0 && reset_at < n) pkt = pkt[0:reset_at - 1];
        model_pkt(reset_at < 0);
        if (reset_at >= 0) exp_rd = 0;
        check("n_writes", 64'(obs.size() - base), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < obs.size(); k++)
            check("write", 64'(obs[base + k]), 64'(exp_q[k]));
        check("row_done", 64'(rd_seen - rd0), 64'(exp_rd));
        check("idle_en", 64'(ctrl_en), 64'hFF);
        if (exp_q.size() > 0)
            check("hold", {32'd0, ctrl_addr, ctrl_wdat}, {32'd0, exp_q[$].addr, exp_q[$].dat});
`ifdef LEDPANEL_LOADER_ERRCNT_EN
        check("err_count", 64'(err_count), 64'(exp_err));
`else
        check("err_count", 64'(err_count), 64'd0);
`endif
    endtask

    task automatic do_reset();
        int n0;
        reset = 1'b1;
        repeat (2) @(posedge display_clock);
        #1;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_en", 64'(ctrl_en), 64'hFF);
        check("rst_addr", 64'(ctrl_addr), 64'd0);
        check("rst_wdat", 64'(ctrl_wdat), 64'd0);
        check("rst_done", 64'(row_done), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        exp_err = 0;
        reset = 1'b0;
        n0 = obs.size();
        @(posedge display_clock); #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);
        repeat (2) @(posedge display_clock);
        #1;
        check("no_wr_after_rst", 64'(obs.size() - n0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge display_clock); #1;
        do_reset();
        // known good row: panel 3, row 5, pixel k = 16'h1000 + k
        make_pkt(8'd3, 8'd5, 130);
        for (int k = 0; k < 64; k++) begin
            pkt[2 + 2 * k] = 8'(k);
            pkt[3 + 2 * k] = 8'h10;
        end
        run_pkt(0, -1);
        make_pkt(8'hFF, 8'd2, 130);
        run_pkt(0, -1);
        make_pkt(8'd1, 8'd31, 130);
        run_pkt(20, -1);
        make_pkt(8'd2, 8'd40, 130);
        run_pkt(0, -1);
        make_pkt(8'd4, 8'd7, 11);
        run_pkt(0, -1);
        make_pkt(8'd5, 8'd9, 140);
        run_pkt(0, -1);
        make_pkt(8'd0, 8'd0, 129);
        run_pkt(10, -1);
        make_pkt(8'd6, 8'd1, 1);
        run_pkt(0, -1);
        for (int p = 0; p < 25; p++) begin
            make_pkt(($urandom_range(15) == 0) ? 8'hFF : 8'($urandom_range(0, 254)),
                     ($urandom_range(7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31)),
                     ($urandom_range(3) == 0) ? $urandom_range(1, 140) : 130);
            run_pkt(30, -1);
        end
        make_pkt(8'd7, 8'd12, 130);
        run_pkt(30, 60);
        do_reset();
        make_pkt(8'd8, 8'd20, 130);
        run_pkt(30, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
